display_link_host: RTL and testbench

// Host end of the two-wire serial register link to the remote display board. Serializes

---
 rtl/display_link_host.sv | 222 ++++++++++++++++++++++
 tb/tb_display_link_host.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_link_host.sv
// -----------------------------------------------------------------------------
// display_link_host
//
// Host end of the two-wire serial register link to the remote display board.
// A register command from the local bus is framed and shifted out on sdo, MSB
// first. c125 is forwarded unchanged on clock_target. For reads, the reply is
// deserialized from sdi and handed back on the rsp_* outputs.
//
// Command frame on sdo (2+ADDR_W+DATA_W bits, MSB first):
//   start(0) | write flag | addr | data (all zeros for reads)
// Reply frame on sdi: start(0) followed by DATA_W data bits, MSB first.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while the link is idle.
// A cmd_valid raised while busy is not queued; it is taken only once
// cmd_ready returns, and only if the requester still holds it. rsp_valid is a
// one-cycle pulse with no back-pressure. rsp_rdata and rsp_timeout keep their
// values until the next pulse.
//
// Ports:
//   c125          in   sole clock, rising edge
//   reset         in   asynchronous, active-low reset
//   clock_target  out  forwarded copy of c125 (never gated)
//   sdo           out  serial command stream, idle high
//   sdi           in   serial reply stream, idle high
//   cmd_valid     in   command request
//   cmd_ready     out  link idle, command can be accepted
//   cmd_write     in   1 = write, 0 = read
//   cmd_addr      in   register address
//   cmd_wdata     in   write data (ignored for reads)
//   rsp_valid     out  read completed or abandoned (one cycle)
//   rsp_rdata     out  read data (0 on timeout)
//   rsp_timeout   out  1 = no reply arrived before TIMEOUT
//   dbg_state     out  current FSM state encoding
// -----------------------------------------------------------------------------
module display_link_host #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int GAP     = 2
) (
    input  logic              c125,
    input  logic              reset,
    output logic              clock_target,
    output logic              sdo,
    input  logic              sdi,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic [2:0]        dbg_state
);

    localparam int FRAME_W = 2 + ADDR_W + DATA_W;
    localparam int CNT_MAX = (FRAME_W > TIMEOUT) ? FRAME_W : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               wr_q;
    logic               sdi_q;
    // Frame without its start bit; the start bit is driven directly on accept.
    logic [FRAME_W-2:0] tx_sh;
    // Holds the DATA_W-1 most recent reply bits; the last bit comes from sdi_q.
    logic [DATA_W-2:0]  rx_sh;
    logic [DATA_W-1:0]  rx_word;
    logic [FRAME_W-1:0] frame_in;

    logic               send_last;
    logic               wait_last;
    logic               recv_last;
    logic               gap_last;

    logic               accept;
    logic               sdo_d;
    logic               rsp_valid_d;
    logic               rsp_to_d;
    logic [DATA_W-1:0]  rsp_rdata_d;

    // The clock goes straight through so the board sees the same edges as this
    // logic, including while reset is asserted.
    assign clock_target = c125;

    assign frame_in = {1'b0, cmd_write, cmd_addr,
                       cmd_write ? cmd_wdata : {DATA_W{1'b0}}};
    assign rx_word  = {rx_sh, sdi_q};

    // Every state counts its own cycles from zero.
    assign send_last = (cnt_q == CNT_W'(FRAME_W - 1));
    assign wait_last = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign recv_last = (cnt_q == CNT_W'(DATA_W - 1));
    assign gap_last  = (cnt_q == CNT_W'(GAP - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge c125 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_SEND;
            ST_SEND: if (send_last) state_d = wr_q ? ST_GAP : ST_WAIT;
            // A reply start bit takes priority over a timeout on the same edge.
            ST_WAIT: begin
                if (!sdi_q)         state_d = ST_RECV;
                else if (wait_last) state_d = ST_GAP;
            end
            ST_RECV: if (recv_last) state_d = ST_GAP;
            ST_GAP:  if (gap_last)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The counter restarts on every state change and rests at zero in IDLE.
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready   = (state_q == ST_IDLE);
        dbg_state   = state_q;
        accept      = 1'b0;
        sdo_d       = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_to_d    = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                accept = cmd_valid;
                // The start bit goes out in the first cycle after acceptance.
                if (cmd_valid) sdo_d = 1'b0;
            end
            ST_SEND: begin
                if (!send_last) sdo_d = tx_sh[FRAME_W-2];
            end
            ST_WAIT: begin
                if (sdi_q && wait_last) begin
                    rsp_valid_d = 1'b1;
                    rsp_to_d    = 1'b1;
                end
            end
            ST_RECV: begin
                if (recv_last) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rx_word;
                end
            end
            default: begin
                sdo_d = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge c125 or negedge reset) begin
        if (!reset) begin
            sdo         <= 1'b1;
            sdi_q       <= 1'b1;
            wr_q        <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            sdo       <= sdo_d;
            sdi_q     <= sdi;
            rsp_valid <= rsp_valid_d;

            if (accept) begin
                wr_q  <= cmd_write;
                tx_sh <= frame_in[FRAME_W-2:0];
            end else if (state_q == ST_SEND) begin
                tx_sh <= {tx_sh[FRAME_W-3:0], 1'b0};
            end

            // Exactly DATA_W shifts happen per reply, so stale bits never leak.
            if (state_q == ST_RECV) begin
                rx_sh <= rx_word[DATA_W-2:0];
            end

            if (rsp_valid_d) begin
                rsp_rdata   <= rsp_rdata_d;
                rsp_timeout <= rsp_to_d;
            end
        end
    end

endmodule

// File: tb/tb_display_link_host.sv
module tb_display_link_host;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 255;
    localparam int GAP     = 2;
    localparam int FRAME_W = 2 + ADDR_W + DATA_W;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        reply;      // target answers the read
        logic [31:0] rword;      // reply word
        logic [7:0]  delay;      // cycles after frame end before reply start bit
        logic        glitch;     // throw low sdi pulses where they must be ignored
        logic [31:0] exp_rdata;
        logic        exp_to;
    } t_vec;

    logic              c125;
    logic              reset;
    logic              clock_target;
    logic              sdo;
    logic              sdi;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    logic [2:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {timeout, rdata} expected for each outstanding read.
    logic [DATA_W:0] exp_q[$];

    t_vec tbl[9];

    display_link_host #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .GAP    (GAP)
    ) dut (
        .c125        (c125),
        .reset       (reset),
        .clock_target(clock_target),
        .sdo         (sdo),
        .sdi         (sdi),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial c125 = 1'b0;
    always #5 c125 = ~c125;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic t_vec mk(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic reply, input logic [31:0] rword, input int delay,
                                input logic glitch, input logic [31:0] exp_rdata, input logic exp_to);
        t_vec v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.reply = reply; v.rword = rword;
        v.delay = 8'(delay); v.glitch = glitch; v.exp_rdata = exp_rdata; v.exp_to = exp_to;
        return v;
    endfunction

    // Reference frame: start 0, write flag, address, data (zero for reads).
    function automatic logic [FRAME_W-1:0] model_frame(input t_vec v);
        logic [DATA_W-1:0] d;
        d = v.wr ? v.wdata : '0;
        return {1'b0, v.wr, v.addr, d};
    endfunction

    // Runs one command. Cycle k is the clock period after the k-th rising edge
    // following acceptance; outputs are sampled and sdi driven at its falling edge.
    // With hold=1, cmd_valid stays high carrying nxt so the follow-up command is
    // accepted the moment the link frees up.
    task automatic run_txn(input t_vec v, input bit hold, input t_vec nxt);
        logic [FRAME_W-1:0] got;
        logic [DATA_W:0]    exp_w;
        logic [DATA_W:0]    pop_w;
        int k, ready_k, rsp_k, rsp_n, idle_err, c, exp_rsp_k, exp_ready_k, bound;

        for (int w = 0; w < 400 && cmd_ready !== 1'b1; w++) @(negedge c125);
        chk("ready_before_cmd", cmd_ready, 1);

        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        exp_w = {v.exp_to, v.exp_rdata};
        if (!v.wr) exp_q.push_back(exp_w);

        // Reply start bit on sdi in cycle c; its data occupies c+1..c+32, the
        // last bit is registered in c+33 and the word is presented in c+34.
        // Without a reply the read is abandoned TIMEOUT cycles after the frame.
        c           = FRAME_W + int'(v.delay);
        exp_rsp_k   = v.wr ? -1 : (v.reply ? c + 2 + DATA_W : FRAME_W + TIMEOUT);
        exp_ready_k = v.wr ? FRAME_W + GAP : exp_rsp_k + GAP;
        bound       = FRAME_W + TIMEOUT + GAP + 100;

        got = '0; ready_k = -1; rsp_k = -1; rsp_n = 0; idle_err = 0; k = 0;
        @(negedge c125);
        cmd_valid = hold;
        if (hold) begin
            cmd_write = nxt.wr; cmd_addr = nxt.addr; cmd_wdata = nxt.wdata;
        end else begin
            // Junk on the bus must not disturb the latched command.
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = 8'($urandom);
            cmd_wdata = $urandom;
        end

        forever begin
            if (k < FRAME_W) got[FRAME_W-1-k] = sdo;
            else if (sdo !== 1'b1) idle_err++;
            if (rsp_valid === 1'b1) begin
                rsp_n++;
                rsp_k = k;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    pop_w = exp_q.pop_front();
                    chk("rsp_word", {rsp_timeout, rsp_rdata}, pop_w);
                end
            end
            if (k > 0 && cmd_ready === 1'b1) begin
                ready_k = k;
                break;
            end
            if (k >= bound) break;

            sdi = 1'b1;
            if (!v.wr && v.reply) begin
                if (k == c) sdi = 1'b0;
                else if (k > c && k <= c + DATA_W) sdi = v.rword[DATA_W-1-(k-c-1)];
            end
            if (v.glitch && (k < 38 || (v.wr && k >= FRAME_W)))
                if ($urandom_range(0, 2) == 0) sdi = 1'b0;

            @(negedge c125);
            k++;
        end
        sdi = 1'b1;

        chk("frame", got, model_frame(v));
        chk("idle_after_frame", idle_err, 0);
        chk("ready_return_cycle", ready_k, exp_ready_k);
        if (v.wr) begin
            chk("write_no_rsp", rsp_n, 0);
        end else begin
            chk("read_rsp_count", rsp_n, 1);
            chk("read_rsp_cycle", rsp_k, exp_rsp_k);
            chk("rsp_hold", {rsp_timeout, rsp_rdata}, exp_w);
        end
        if (exp_q.size() != 0) begin
            chk("rsp_missing", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        t_vec v, v2;
        int bad;

        reset = 1'b0; sdi = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;

        // Reset state and the forwarded clock while reset is held.
        repeat (2) @(negedge c125);
        chk("rst_sdo", sdo, 1);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_timeout", rsp_timeout, 0);
        chk("rst_state", dbg_state, 0);
        chk("clk_fwd_low_in_reset", clock_target, 0);
        @(posedge c125); #1;
        chk("clk_fwd_high_in_reset", clock_target, 1);
        @(negedge c125);
        reset = 1'b1;
        repeat (2) begin
            @(posedge c125); #1;
            chk("clk_fwd_high", clock_target, 1);
            @(negedge c125);
            chk("clk_fwd_low", clock_target, 0);
            chk("post_rst_sdo", sdo, 1);
            chk("post_rst_ready", cmd_ready, 1);
            chk("post_rst_rsp_valid", rsp_valid, 0);
        end

        // Directed table: inputs and expected read results.
        tbl[0] = mk(1, 8'h12, 32'hDEADBEEF, 0, 32'h0,        0,  0, 32'h0,        0);
        tbl[1] = mk(0, 8'h05, 32'h0,        1, 32'h12345678, 0,  0, 32'h12345678, 0);
        tbl[2] = mk(0, 8'h33, 32'hAAAAAAAA, 0, 32'h0,        0,  0, 32'h0,        1);
        tbl[3] = mk(1, 8'h00, 32'h00000000, 0, 32'h0,        0,  0, 32'h0,        0);
        tbl[4] = mk(1, 8'hFF, 32'hFFFFFFFF, 0, 32'h0,        0,  1, 32'h0,        0);
        tbl[5] = mk(0, 8'hA5, 32'h0,        1, 32'h80000001, 7,  1, 32'h80000001, 0);
        tbl[6] = mk(0, 8'h5A, 32'h0,        1, 32'h00000000, 60, 0, 32'h00000000, 0);
        tbl[7] = mk(0, 8'h01, 32'h0,        1, 32'hFFFFFFFF, 1,  0, 32'hFFFFFFFF, 0);
        tbl[8] = mk(1, 8'h80, 32'h00000001, 0, 32'h0,        0,  1, 32'h0,        0);
        for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b0, tbl[i]);

        // cmd_valid held through a write, then through a read: the follow-up is
        // taken only after the gap and produces exactly its own frame.
        v  = mk(1, 8'h44, 32'h11223344, 0, 32'h0, 0, 0, 32'h0, 0);
        v2 = mk(0, 8'h55, 32'h55667788, 1, 32'hCAFEF00D, 3, 0, 32'hCAFEF00D, 0);
        run_txn(v, 1'b1, v2);
        v  = mk(1, 8'h66, 32'h0BADF00D, 0, 32'h0, 0, 0, 32'h0, 0);
        run_txn(v2, 1'b1, v);
        run_txn(v, 1'b0, v);

        // Reset pulsed in the middle of a write frame.
        for (int w = 0; w < 400 && cmd_ready !== 1'b1; w++) @(negedge c125);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h0F; cmd_wdata = 32'h0;
        @(negedge c125);
        cmd_valid = 1'b0;
        repeat (10) @(negedge c125);
        chk("mid_send_sdo", sdo, 0);
        #2 reset = 1'b0;
        #1;
        chk("abort_sdo", sdo, 1);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_state", dbg_state, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        @(posedge c125); #1;
        chk("clk_fwd_abort", clock_target, 1);
        @(negedge c125);
        reset = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge c125);
            if (sdo !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        chk("after_abort_quiet", bad, 0);
        v = mk(1, 8'h3C, 32'hA5A55A5A, 0, 32'h0, 0, 0, 32'h0, 0);
        run_txn(v, 1'b0, v);

        // Random traffic checked against the reference frame/timing model.
        for (int i = 0; i < 25; i++) begin
            v.wr     = 1'($urandom_range(0, 1));
            v.addr   = 8'($urandom);
            v.wdata  = $urandom;
            v.reply  = ($urandom_range(0, 3) != 0);
            v.rword  = $urandom;
            v.delay  = 8'($urandom_range(0, 40));
            v.glitch = 1'($urandom_range(0, 1));
            v.exp_to    = !v.reply;
            v.exp_rdata = v.reply ? v.rword : 32'h0;
            run_txn(v, 1'b0, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
